// File: rtl/pwm_generator.sv
// pwm_generator: double-buffered, prescaled PWM waveform core.
// Ports: clock/reset (sync, active-high), enable (run control), load (capture strobe),
//        period_in/duty_in/prescale_in (new settings), pwm_out (registered waveform),
//        period_done (one-cycle wrap pulse), update_pending (settings waiting for a boundary),
//        count (active counter read-back).
module pwm_generator #(
  parameter int WIDTH = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [WIDTH-1:0]          duty_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale_in,
  output logic                      pwm_out,
  output logic                      period_done,
  output logic                      update_pending,
  output logic [WIDTH-1:0]          count
);
  logic [WIDTH-1:0] per_p, duty_p, per_a, duty_a;
  logic [PRESCALE_WIDTH-1:0] pre_p, pre_a, pcnt;
  logic tick, wrap, apply;
  always_comb begin
    tick = enable & (pcnt == pre_a);
    wrap = tick & (count == per_a);
    // Settings swap at a period boundary, or at once while stopped.
    apply = !enable | wrap;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt <= '0;
      count <= '0;
      period_done <= 1'b0;
      pwm_out <= 1'b0;
      update_pending <= 1'b0;
      per_p <= '0;
      duty_p <= '0;
      pre_p <= '0;
      per_a <= '0;
      duty_a <= '0;
      pre_a <= '0;
    end else begin
      pcnt <= (!enable || tick) ? '0 : pcnt + 1'b1;
      count <= !enable ? '0 : tick ? (wrap ? '0 : count + 1'b1) : count;
      period_done <= wrap;
      pwm_out <= enable & (count < duty_a);
      if (load) begin
        per_p <= period_in;
        duty_p <= duty_in;
        pre_p <= prescale_in;
      end
      // A load landing on a boundary bypasses the pending set entirely.
      if (apply && load) begin
        per_a <= period_in;
        duty_a <= duty_in;
        pre_a <= prescale_in;
      end else if (apply && update_pending) begin
        per_a <= per_p;
        duty_a <= duty_p;
        pre_a <= pre_p;
      end
      update_pending <= !apply & (load | update_pending);
    end
  end
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed self-checking bench for pwm_generator.
module tb_pwm_generator;
  logic clock = 1'b0;
  logic reset, enable, load;
  logic [15:0] period_in, duty_in, count;
  logic [7:0] prescale_in;
  logic pwm_out, period_done, update_pending;
  int tests = 0;
  int fails = 0;

  pwm_generator #(.WIDTH(16), .PRESCALE_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .period_in(period_in), .duty_in(duty_in), .prescale_in(prescale_in),
    .pwm_out(pwm_out), .period_done(period_done),
    .update_pending(update_pending), .count(count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setv(input logic [15:0] p, input logic [15:0] d, input logic [7:0] s);
    period_in = p;
    duty_in = d;
    prescale_in = s;
  endtask

  task automatic load_stopped(input logic [15:0] p, input logic [15:0] d, input logic [7:0] s);
    enable = 1'b0;
    setv(p, d, s);
    load = 1'b1;
    step();
    load = 1'b0;
    chk("stopped_load_no_pending", update_pending, 0);
    enable = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0;
    setv(0, 0, 0);
    step();
    reset = 1'b0;
    chk("rst_pwm", pwm_out, 0);
    chk("rst_done", period_done, 0);
    chk("rst_pend", update_pending, 0);
    chk("rst_count", count, 0);

    // 1: period 3, duty 2, prescale 0 -> 1,1,0,0
    load_stopped(3, 2, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t1_count", count, k % 4);
      chk("t1_pwm", pwm_out, ((k - 1) % 4) < 2);
      chk("t1_done", period_done, (k % 4) == 0);
    end

    // 2: prescale 2, period 1, duty 1 -> 3 high, 3 low
    load_stopped(1, 1, 2);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t2_pwm", pwm_out, (k <= 3) || (k == 7));
      chk("t2_count", count, (k >= 3) && (k <= 5));
      chk("t2_done", period_done, k == 6);
    end

    // 3: duty change mid-period waits for the wrap
    load_stopped(3, 2, 0);
    step();
    chk("t3_pwm1", pwm_out, 1);
    step();
    chk("t3_pwm2", pwm_out, 1);
    setv(3, 1, 0);
    load = 1'b1;
    step();
    load = 1'b0;
    chk("t3_pend_set", update_pending, 1);
    chk("t3_pwm3", pwm_out, 0);
    step();
    chk("t3_pend_clr", update_pending, 0);
    chk("t3_done4", period_done, 1);
    chk("t3_pwm4", pwm_out, 0);
    step();
    chk("t3_pwm5", pwm_out, 1);
    step();
    chk("t3_pwm6", pwm_out, 0);
    step();
    chk("t3_pwm7", pwm_out, 0);
    step();
    chk("t3_pwm8", pwm_out, 0);
    chk("t3_done8", period_done, 1);

    // 4: duty 0 -> constant low; duty 5 > period 3 -> constant high
    load_stopped(3, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t4_pwm_lo", pwm_out, 0);
      chk("t4_done_lo", period_done, (k % 4) == 0);
    end
    load_stopped(3, 5, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t4_pwm_hi", pwm_out, 1);
      chk("t4_done_hi", period_done, 0);
    end

    // 5: load coinciding with the wrap goes straight to the active set
    setv(1, 1, 0);
    load = 1'b1;
    step();
    load = 1'b0;
    chk("t5_pend4", update_pending, 0);
    chk("t5_done4", period_done, 1);
    chk("t5_pwm4", pwm_out, 1);
    step();
    chk("t5_pwm5", pwm_out, 1);
    chk("t5_count5", count, 1);
    step();
    chk("t5_pwm6", pwm_out, 0);
    chk("t5_done6", period_done, 1);
    chk("t5_pend6", update_pending, 0);
    step();
    chk("t5_pwm7", pwm_out, 1);
    step();
    chk("t5_done8", period_done, 1);

    // 6: reset with a load pending, then restart with zeroed settings
    setv(3, 2, 0);
    load = 1'b1;
    step();
    load = 1'b0;
    chk("t6_pend", update_pending, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_pwm", pwm_out, 0);
    chk("t6_rst_done", period_done, 0);
    chk("t6_rst_pend", update_pending, 0);
    chk("t6_rst_count", count, 0);
    enable = 1'b0;
    step();
    chk("t6_off_pwm", pwm_out, 0);
    chk("t6_off_pend", update_pending, 0);
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t6_pwm", pwm_out, 0);
      chk("t6_count", count, 0);
      chk("t6_done", period_done, 1);
    end
    enable = 1'b0;
    step();
    chk("t6_stop_done", period_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
